// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the hazard/forwarding logic.
package hazard_pkg;

  localparam int unsigned FWD_NONE       = 0;
  localparam int unsigned FWD_STAGE_BASE = 1;
  localparam int unsigned REG_ZERO       = 0;

  function automatic int unsigned sel_width(input int unsigned num_fwd);
    return (num_fwd + 1 <= 2) ? 1 : $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Operand forwarding selects, long-latency register scoreboard and ID-stage
// stall generation with a saturating stall-cycle counter.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter  int unsigned NUM_REGS = 32,
  parameter  int unsigned NUM_SRC  = 2,
  parameter  int unsigned NUM_FWD  = 2,
  parameter  int unsigned CNT_W    = 32,
  localparam int unsigned REG_W    = $clog2(NUM_REGS),
  localparam int unsigned SEL_W    = sel_width(NUM_FWD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*REG_W-1:0] ex_rs,
  input  logic [NUM_FWD*REG_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]       fwd_regwrite,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  input  logic [NUM_SRC*REG_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic [REG_W-1:0]         ex_rd,
  input  logic                     ex_mem_read,
  input  logic                     mc_issue,
  input  logic [REG_W-1:0]         mc_rd,
  input  logic                     mc_wb,
  input  logic [REG_W-1:0]         mc_wb_rd,
  input  logic                     clr_cnt,
  output logic                     stall,
  output logic [NUM_REGS-1:0]      busy,
  output logic [CNT_W-1:0]         stall_cnt
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_FWD-1:0]  fwd_hit [NUM_SRC];
  logic [NUM_SRC-1:0]  load_use_vec;
  logic [NUM_SRC-1:0]  raw_vec;
  logic                waw_hazard;
  logic                issue_eff;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_W-1:0] ex_src;
    logic [REG_W-1:0] id_src;
    logic [SEL_W-1:0] sel;
    logic             found;

    assign ex_src = ex_rs[i*REG_W +: REG_W];
    assign id_src = id_rs[i*REG_W +: REG_W];

    for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
      logic [REG_W-1:0] stage_rd;
      assign stage_rd      = fwd_rd[k*REG_W +: REG_W];
      assign fwd_hit[i][k] = fwd_regwrite[k] && (stage_rd != REG_W'(REG_ZERO)) &&
                             (stage_rd == ex_src);
    end

    // Lowest-numbered (youngest) matching stage wins.
    always_comb begin
      sel   = SEL_W'(FWD_NONE);
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_FWD; k++) begin
        if (!found && fwd_hit[i][k]) begin
          found = 1'b1;
          sel   = SEL_W'(k + FWD_STAGE_BASE);
        end
      end
    end

    assign fwd_sel[i*SEL_W +: SEL_W] = sel;
    assign load_use_vec[i] = ex_mem_read && (ex_rd != REG_W'(REG_ZERO)) &&
                             id_rs_used[i] && (id_src == ex_rd);
    assign raw_vec[i]      = id_rs_used[i] && busy_q[id_src];
  end

  assign waw_hazard = mc_issue && busy_q[mc_rd];
  assign stall      = (|load_use_vec) || (|raw_vec) || waw_hazard;
  assign issue_eff  = mc_issue && !stall && (mc_rd != REG_W'(REG_ZERO));

  // Issue is applied after writeback so a same-register set wins over the clear.
  always_comb begin
    busy_d = busy_q;
    if (mc_wb) begin
      busy_d[mc_wb_rd] = 1'b0;
    end
    if (issue_eff) begin
      busy_d[mc_rd] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (stall),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench: vector table, directed multi-cycle sequences and
// randomized traffic against a behavioural scoreboard model.
module tb_hazard_scoreboard_unit;

  localparam int NUM_REGS = 32;
  localparam int NUM_SRC  = 2;
  localparam int NUM_FWD  = 2;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [4:0] ex_rs_a [2];
  logic [4:0] fwd_rd_a[2];
  logic [4:0] id_rs_a [2];
  logic [9:0] ex_rs, fwd_rd, id_rs;
  logic [1:0] fwd_regwrite, id_rs_used;
  logic [4:0] ex_rd, mc_rd, mc_wb_rd;
  logic       ex_mem_read, mc_issue, mc_wb, clr_cnt;
  logic [3:0] fwd_sel;
  logic       stall;
  logic [31:0] busy;
  logic [3:0] stall_cnt;

  assign ex_rs  = {ex_rs_a[1], ex_rs_a[0]};
  assign fwd_rd = {fwd_rd_a[1], fwd_rd_a[0]};
  assign id_rs  = {id_rs_a[1], id_rs_a[0]};

  bit ref_busy[32];
  int ref_cnt;
  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard_unit #(
    .NUM_REGS(NUM_REGS),
    .NUM_SRC (NUM_SRC),
    .NUM_FWD (NUM_FWD),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_rs        (ex_rs),
    .fwd_rd       (fwd_rd),
    .fwd_regwrite (fwd_regwrite),
    .fwd_sel      (fwd_sel),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .mc_issue     (mc_issue),
    .mc_rd        (mc_rd),
    .mc_wb        (mc_wb),
    .mc_wb_rd     (mc_wb_rd),
    .clr_cnt      (clr_cnt),
    .stall        (stall),
    .busy         (busy),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic int m_sel(input int rs);
    for (int k = 0; k < 2; k++)
      if (fwd_regwrite[k] && fwd_rd_a[k] != 0 && int'(fwd_rd_a[k]) == rs) return k + 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    bit h = 0;
    for (int i = 0; i < 2; i++) begin
      if (ex_mem_read && ex_rd != 0 && id_rs_used[i] && id_rs_a[i] == ex_rd) h = 1;
      if (id_rs_used[i] && ref_busy[id_rs_a[i]]) h = 1;
    end
    if (mc_issue && ref_busy[mc_rd]) h = 1;
    return h;
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = ref_busy[r];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) ref_busy[r] = 0;
      ref_cnt = 0;
    end else begin
      bit s;
      s = m_stall();
      if (mc_wb) ref_busy[mc_wb_rd] = 0;
      if (mc_issue && !s && mc_rd != 0) ref_busy[mc_rd] = 1;
      if (clr_cnt) ref_cnt = 0;
      else if (s && ref_cnt < 15) ref_cnt = ref_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " fwd_sel0"}, 32'(fwd_sel[1:0]), 32'(m_sel(int'(ex_rs_a[0]))));
    chk({tag, " fwd_sel1"}, 32'(fwd_sel[3:2]), 32'(m_sel(int'(ex_rs_a[1]))));
    chk({tag, " stall"}, 32'(stall), 32'(m_stall()));
    chk({tag, " busy"}, busy, m_busy_vec());
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(ref_cnt));
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      ex_rs_a[i] = '0; fwd_rd_a[i] = '0; id_rs_a[i] = '0;
    end
    fwd_regwrite = '0; id_rs_used = '0; ex_rd = '0; ex_mem_read = 0;
    mc_issue = 0; mc_rd = '0; mc_wb = 0; mc_wb_rd = '0; clr_cnt = 0;
  endtask

  task automatic load_use_on();
    ex_mem_read = 1; ex_rd = 5'd7; id_rs_a[1] = 5'd7; id_rs_used = 2'b10;
  endtask

  typedef struct {
    logic [4:0] ers0, ers1, frd0, frd1;
    logic [1:0] we;
    logic [4:0] irs0, irs1;
    logic [1:0] used;
    logic [4:0] erd;
    logic       mr;
    logic [1:0] s0, s1;
    logic       st;
  } vec_t;

  vec_t vecs[9];

  initial begin
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("reset busy", busy, 32'h0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'h0);
    rst = 0;

    //         ers0  ers1  frd0  frd1  we     irs0  irs1  used   erd   mr  s0 s1 st
    vecs[0] = '{5'd5, 5'd0, 5'd5, 5'd5, 2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 0, 1, 0, 0};
    vecs[1] = '{5'd5, 5'd0, 5'd5, 5'd5, 2'b10, 5'd0, 5'd0, 2'b00, 5'd0, 0, 2, 0, 0};
    vecs[2] = '{5'd5, 5'd0, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 0, 0};
    vecs[3] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 0, 0};
    vecs[4] = '{5'd4, 5'd6, 5'd6, 5'd4, 2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 0, 2, 1, 0};
    vecs[5] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd7, 2'b10, 5'd7, 1, 0, 0, 1};
    vecs[6] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd7, 2'b00, 5'd7, 1, 0, 0, 0};
    vecs[7] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd3, 5'd7, 2'b01, 5'd7, 1, 0, 0, 0};
    vecs[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b01, 5'd0, 1, 0, 0, 0};

    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      idle();
      ex_rs_a[0] = vecs[v].ers0; ex_rs_a[1] = vecs[v].ers1;
      fwd_rd_a[0] = vecs[v].frd0; fwd_rd_a[1] = vecs[v].frd1;
      fwd_regwrite = vecs[v].we;
      id_rs_a[0] = vecs[v].irs0; id_rs_a[1] = vecs[v].irs1;
      id_rs_used = vecs[v].used; ex_rd = vecs[v].erd; ex_mem_read = vecs[v].mr;
      #1;
      chk($sformatf("vec%0d fwd_sel0", v), 32'(fwd_sel[1:0]), 32'(vecs[v].s0));
      chk($sformatf("vec%0d fwd_sel1", v), 32'(fwd_sel[3:2]), 32'(vecs[v].s1));
      chk($sformatf("vec%0d stall", v), 32'(stall), 32'(vecs[v].st));
    end

    // RAW on a busy register and release one cycle after writeback
    @(negedge clk); idle(); mc_issue = 1; mc_rd = 5'd9; #1;
    chk("raw issue stall", 32'(stall), 32'h0);
    @(negedge clk); idle(); id_rs_a[0] = 5'd9; id_rs_used = 2'b01; #1;
    chk("raw busy9", 32'(busy[9]), 32'h1);
    chk("raw stall", 32'(stall), 32'h1);
    check_all("raw");
    @(negedge clk); mc_wb = 1; mc_wb_rd = 5'd9; #1;
    chk("raw wb cycle stall", 32'(stall), 32'h1);
    @(negedge clk); mc_wb = 0; #1;
    chk("raw released stall", 32'(stall), 32'h0);
    chk("raw released busy9", 32'(busy[9]), 32'h0);

    // Same-cycle set/clear, WAW, and issue to r0
    @(negedge clk); idle(); mc_issue = 1; mc_rd = 5'd3; mc_wb = 1; mc_wb_rd = 5'd3; #1;
    chk("setclr stall", 32'(stall), 32'h0);
    @(negedge clk); idle(); #1;
    chk("setclr busy", busy, 32'h8);
    @(negedge clk); mc_issue = 1; mc_rd = 5'd3; #1;
    chk("waw stall", 32'(stall), 32'h1);
    @(negedge clk); idle(); #1;
    chk("waw busy", busy, 32'h8);
    @(negedge clk); mc_issue = 1; mc_rd = 5'd0; #1;
    chk("r0 issue stall", 32'(stall), 32'h0);
    @(negedge clk); idle(); #1;
    chk("r0 issue busy", busy, 32'h8);
    @(negedge clk); mc_wb = 1; mc_wb_rd = 5'd3;
    @(negedge clk); idle(); #1;
    chk("wb r3 busy", busy, 32'h0);

    // Counter saturation and clear priority
    @(negedge clk); idle(); clr_cnt = 1;
    @(negedge clk); idle(); #1;
    chk("cnt cleared", 32'(stall_cnt), 32'h0);
    load_use_on();
    repeat (20) @(negedge clk);
    #1;
    chk("cnt saturate", 32'(stall_cnt), 32'd15);
    chk("cnt sat stall", 32'(stall), 32'h1);
    clr_cnt = 1;
    @(negedge clk); #1;
    chk("cnt clr over inc", 32'(stall_cnt), 32'h0);
    check_all("cnt");

    // Asynchronous reset between clock edges
    @(negedge clk); idle(); mc_issue = 1; mc_rd = 5'd9;
    @(negedge clk); idle(); load_use_on();
    repeat (6) @(negedge clk);
    #1;
    chk("pre-rst busy", busy, 32'h200);
    chk("pre-rst cnt", 32'(stall_cnt), 32'd6);
    #1 rst = 1;
    #1;
    chk("async rst busy", busy, 32'h0);
    chk("async rst cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk); rst = 0; idle();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        ex_rs_a[i]  = 5'($urandom_range(0, 7));
        fwd_rd_a[i] = 5'($urandom_range(0, 7));
        id_rs_a[i]  = 5'($urandom_range(0, 7));
      end
      fwd_regwrite = 2'($urandom);
      id_rs_used   = 2'($urandom);
      ex_rd        = 5'($urandom_range(0, 7));
      ex_mem_read  = ($urandom_range(0, 3) == 0);
      mc_issue     = ($urandom_range(0, 2) == 0);
      mc_rd        = 5'($urandom_range(0, 7));
      mc_wb        = ($urandom_range(0, 1) == 0);
      mc_wb_rd     = 5'($urandom_range(0, 7));
      clr_cnt      = ($urandom_range(0, 15) == 0);
      #1;
      check_all($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised successor to the pipeline's operand-forwarding logic. It generates per-operand forward selects for any number of source operands and forwarding stages. It also keeps a register scoreboard for long-latency results (mul/div, variable-latency loads) and raises a single ID-stage stall for load-use, RAW-on-busy and WAW-on-busy hazards. It sits beside the ID/EX pipeline register, feeding the EX operand muxes and the PC/IF-ID hold logic, and exports a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- NUM_REGS, 32: architectural registers; REG_W = $clog2(NUM_REGS) is derived locally.
- NUM_SRC, 2: source operands per instruction.
- NUM_FWD, 2: forwarding stages; stage 0 = youngest (EX/MEM), stage 1 = MEM/WB.
- CNT_W, 32: stall counter width. SEL_W = $clog2(NUM_FWD+1) is derived.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ex_rs  in  NUM_SRC*REG_W  sources of the instruction in ID/EX; operand i at [i*REG_W +: REG_W]
- fwd_rd  in  NUM_FWD*REG_W  destination register per forwarding stage
- fwd_regwrite  in  NUM_FWD  write-enable per forwarding stage
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k+1 = forward from stage k
- id_rs  in  NUM_SRC*REG_W  sources of the instruction in IF/ID
- id_rs_used  in  NUM_SRC  operand i is actually read
- ex_rd  in  REG_W  destination of the instruction in ID/EX
- ex_mem_read  in  1  instruction in ID/EX is a load
- mc_issue  in  1  instruction in ID is a long-latency op
- mc_rd  in  REG_W  its destination
- mc_wb  in  1  long-latency result written back this cycle
- mc_wb_rd  in  REG_W  register being written back
- clr_cnt  in  1  synchronous clear of stall_cnt
- stall  out  1  hold PC and IF/ID, bubble ID/EX
- busy  out  NUM_REGS  scoreboard bits
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Forwarding (combinational): for each operand i, fwd_sel = k+1 for the lowest k with fwd_regwrite[k], fwd_rd[k] != 0 and fwd_rd[k] == ex_rs[i]. The youngest stage wins. If no stage matches, fwd_sel = 0. Register 0 is never forwarded.
- Load-use hazard: ex_mem_read, ex_rd != 0, id_rs_used[i] and id_rs[i] == ex_rd, for any i.
- RAW-busy hazard: id_rs_used[i] and busy[id_rs[i]], for any i.
- WAW-busy hazard: mc_issue and busy[mc_rd].
- stall is the OR of all three hazards and is combinational.
- Effective issue is mc_issue & ~stall & (mc_rd != 0).
- On an effective issue, busy[mc_rd] is set at the next edge.
- mc_wb clears busy[mc_wb_rd] at the next edge.
- If an effective issue and mc_wb target the same register in one cycle, the set wins.
- mc_wb to a non-busy register, or to register 0, has no effect.
- busy[0] is constantly 0.
- stall_cnt:
  - clr_cnt set: next value 0 (takes priority over increment).
  - stall set: increment by 1, holding at all-ones (saturate).
  - Otherwise: hold.

## Timing
- Reset values: busy = 0, stall_cnt = 0. With busy cleared, stall and fwd_sel are purely input-driven.
- Reset asserted mid-operation clears the scoreboard immediately. Long-latency ops in flight at reset are the pipeline's responsibility to squash.
- fwd_sel and stall have zero latency: combinational in the same cycle.
- Scoreboard latency:
  - The busy bit is visible in the cycle after issue. The following instruction therefore sees busy=1 on its first ID cycle.
  - A register written back by mc_wb in cycle N still stalls readers in cycle N. They are released in cycle N+1, so no same-cycle register-file bypass is assumed.
- A load-use stall lasts exactly 1 cycle, because the load then moves to EX/MEM and forwarding takes over.

## Structure
- Shared package `hazard_pkg`:
  - SEL_W computation function.
  - Localparams FWD_NONE = 0 and FWD_STAGE_BASE = 1.
  - Register-0 constant.
- Natural sub-module: `sat_counter` (parameter width, ports clk, rst, clr, inc, count). It is reusable by other performance counters.
- The scoreboard and the comparators stay in this module as generate loops over NUM_SRC and NUM_FWD.

## Test plan
- Forwarding priority: ex_rs[0] = 5, stage 0 and stage 1 both write r5 -> fwd_sel[0] = 1. Stage 0 write-enable low -> fwd_sel[0] = 2. With rd = 0 in both stages -> fwd_sel[0] = 0.
- Load-use: ex_mem_read = 1, ex_rd = 7, id_rs[1] = 7, id_rs_used = 2'b10 -> stall = 1 for one cycle. With id_rs_used = 0 -> stall = 0.
- Scoreboard RAW:
  - Issue mc_rd = 9; next cycle id_rs[0] = 9 -> stall = 1, busy[9] = 1.
  - mc_wb_rd = 9 in cycle N -> stall is still 1 in N and drops to 0 in N+1.
- Same-cycle set/clear and WAW:
  - Issue r3 while mc_wb r3 -> busy[3] stays 1.
  - mc_issue to busy r3 -> stall = 1 and busy is unchanged.
  - Issue r0 -> busy stays 0.
- Counter: CNT_W = 4, hold stall for 20 cycles -> stall_cnt saturates at 15. clr_cnt together with stall -> next value 0.
- Async reset: assert rst mid-sequence with busy = 0x200 and stall_cnt = 6 -> both read 0 before the next clock edge.
